// File: rtl/jk_stim_sequencer.sv
// jk_stim_sequencer: FIFO-fed JK command sequencer with read-back check.
// Define JK_SEQ_SELFCHECK_EN to enable the read-back compare logic.
module jk_stim_sequencer #(
  parameter int DEPTH = 4,
  parameter int GAP   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  output logic       j,
  output logic       k,
  input  logic       q_in,
  input  logic       q_bar_in,
  output logic       busy,
  output logic       done_pulse,
  output logic       exp_q,
  output logic       mismatch,
  output logic [7:0] err_count
);

  localparam int AW  = $clog2(DEPTH);
  localparam int GM1 = (GAP > 0) ? GAP - 1 : 0;
  localparam logic [AW:0]   FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   C_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] P_ONE = AW'(1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;
  localparam logic [1:0] WAIT  = 2'd3;

  logic [1:0]    state;
  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [3:0]    gap_cnt;
  logic          empty;
  logic          push;
  logic          pop;
  logic          go;

  assign empty     = (count == '0);
  assign cmd_ready = (count != FULL);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = go && !empty;
  assign busy      = !empty || (state != IDLE);

  // States that may launch the next command this edge.
  always_comb begin
    go = 1'b0;
    unique case (state)
      IDLE:    go = 1'b1;
      CHECK:   go = (GAP == 0);
      WAIT:    go = (gap_cnt == 4'd0);
      default: go = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_op;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + P_ONE;
      if (pop)  rd_ptr <= rd_ptr + P_ONE;
      if (push && !pop)      count <= count + C_ONE;
      else if (pop && !push) count <= count - C_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      j          <= 1'b0;
      k          <= 1'b0;
      exp_q      <= 1'b0;
      done_pulse <= 1'b0;
      gap_cnt    <= '0;
    end else begin
      done_pulse <= 1'b0;
      j          <= 1'b0;
      k          <= 1'b0;
      if (pop) begin
        {j, k} <= mem[rd_ptr];
        state  <= DRIVE;
      end
      unique case (state)
        IDLE: ;
        DRIVE: begin
          state <= CHECK;
          // Reference model follows the same edge the flip-flop samples.
          unique case ({j, k})
            2'b01:   exp_q <= 1'b0;
            2'b10:   exp_q <= 1'b1;
            2'b11:   exp_q <= !exp_q;
            default: ;
          endcase
        end
        CHECK: begin
          done_pulse <= 1'b1;
          if (GAP > 0) begin
            state   <= WAIT;
            gap_cnt <= 4'(GM1);
          end else if (!pop) begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (!go)       gap_cnt <= gap_cnt - 4'd1;
          else if (!pop) state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef JK_SEQ_SELFCHECK_EN
  logic bad;
  assign bad = (q_in != exp_q) || (q_bar_in != !q_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mismatch  <= 1'b0;
      err_count <= '0;
    end else if (state == CHECK && bad) begin
      mismatch <= 1'b1;
      if (err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end
`else
  logic unused_rb;
  assign unused_rb = q_in ^ q_bar_in;
  assign mismatch  = 1'b0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_jk_stim_sequencer.sv
// tb_jk_stim_sequencer: directed tests for jk_stim_sequencer with
// behavioural JK flip-flops attached to a GAP=0 and a GAP=3 instance.
module tb_jk_stim_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

`ifdef JK_SEQ_SELFCHECK_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif

  logic       cv0 = 1'b0, cr0, j0, k0, qi0, qb0;
  logic       busy0, done0, eq0, mm0, ffq0, fault = 1'b0;
  logic [1:0] op0 = 2'b00;
  logic [7:0] ec0;

  logic       cv3 = 1'b0, cr3, j3, k3, qi3, qb3;
  logic       busy3, done3, eq3, mm3, ffq3;
  logic [1:0] op3 = 2'b00;
  logic [7:0] ec3;

  jk_stim_sequencer #(.DEPTH(4), .GAP(0)) u0 (
    .clk(clk), .rst(rst), .cmd_valid(cv0), .cmd_ready(cr0),
    .cmd_op(op0), .j(j0), .k(k0), .q_in(qi0), .q_bar_in(qb0),
    .busy(busy0), .done_pulse(done0), .exp_q(eq0),
    .mismatch(mm0), .err_count(ec0)
  );

  jk_stim_sequencer #(.DEPTH(4), .GAP(3)) u3 (
    .clk(clk), .rst(rst), .cmd_valid(cv3), .cmd_ready(cr3),
    .cmd_op(op3), .j(j3), .k(k3), .q_in(qi3), .q_bar_in(qb3),
    .busy(busy3), .done_pulse(done3), .exp_q(eq3),
    .mismatch(mm3), .err_count(ec3)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ffq0 <= 1'b0;
    else case ({j0, k0})
      2'b01:   ffq0 <= 1'b0;
      2'b10:   ffq0 <= 1'b1;
      2'b11:   ffq0 <= ~ffq0;
      default: ffq0 <= ffq0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ffq3 <= 1'b0;
    else case ({j3, k3})
      2'b01:   ffq3 <= 1'b0;
      2'b10:   ffq3 <= 1'b1;
      2'b11:   ffq3 <= ~ffq3;
      default: ffq3 <= ffq3;
    endcase
  end

  assign qi0 = fault ? 1'b0 : ffq0;
  assign qb0 = ~ffq0;
  assign qi3 = ffq3;
  assign qb3 = ~ffq3;

  task automatic wait_idle0(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (!busy0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    total++; if (j0 !== 1'b0) $display("FAIL rst_j got %b want 0", j0); else passed++;
    total++; if (k0 !== 1'b0) $display("FAIL rst_k got %b want 0", k0); else passed++;
    total++; if (cr0 !== 1'b1) $display("FAIL rst_ready got %b want 1", cr0); else passed++;
    total++; if (busy0 !== 1'b0) $display("FAIL rst_busy got %b want 0", busy0); else passed++;
    total++; if (eq0 !== 1'b0) $display("FAIL rst_expq got %b want 0", eq0); else passed++;
    total++; if (done0 !== 1'b0) $display("FAIL rst_done got %b want 0", done0); else passed++;
    total++; if (mm0 !== 1'b0) $display("FAIL rst_mm got %b want 0", mm0); else passed++;
    total++; if (ec0 !== 8'd0) $display("FAIL rst_ec got %0d want 0", ec0); else passed++;
    total++; if (cr3 !== 1'b1) $display("FAIL rst_ready3 got %b want 1", cr3); else passed++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [1:0] ops [4];
    logic       want_q [4];
    logic [1:0] got [$];
    int         cyc [$];
    logic       qs [$];
    int         dcnt = 0;
    bit         prev = 1'b0;
    ops    = '{2'b10, 2'b11, 2'b11, 2'b01};
    want_q = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int c = 0; c < 13; c++) begin
      if (prev) qs.push_back(eq0);
      prev = ({j0, k0} != 2'b00);
      if (prev) begin got.push_back({j0, k0}); cyc.push_back(c); end
      if (done0) dcnt++;
      cv0 = (c < 4);
      op0 = (c < 4) ? ops[c] : 2'b00;
      @(negedge clk);
    end
    total++; if (got.size() != 4) $display("FAIL b2b_npulse got %0d want 4", got.size()); else passed++;
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      total++; if (got[i] !== ops[i]) $display("FAIL b2b_jk%0d got %b want %b", i, got[i], ops[i]); else passed++;
      total++; if (cyc[i] != 2 + 2*i) $display("FAIL b2b_cyc%0d got %0d want %0d", i, cyc[i], 2 + 2*i); else passed++;
    end
    for (int i = 0; i < 4 && i < qs.size(); i++) begin
      total++; if (qs[i] !== want_q[i]) $display("FAIL b2b_expq%0d got %b want %b", i, qs[i], want_q[i]); else passed++;
    end
    total++; if (dcnt != 4) $display("FAIL b2b_done got %0d want 4", dcnt); else passed++;
    total++; if (mm0 !== 1'b0) $display("FAIL b2b_mm got %b want 0", mm0); else passed++;
    total++; if (busy0 !== 1'b0) $display("FAIL b2b_busy got %b want 0", busy0); else passed++;
  endtask

  task automatic test_gap_hold();
    int  dn [$];
    bit  seen = 1'b0;
    logic b11 = 1'b0, b12 = 1'b1;
    for (int c = 0; c < 15; c++) begin
      if (j3 || k3) seen = 1'b1;
      if (done3) dn.push_back(c);
      if (c == 11) b11 = busy3;
      if (c == 12) b12 = busy3;
      cv3 = (c < 2);
      op3 = 2'b00;
      @(negedge clk);
    end
    total++; if (seen) $display("FAIL gap_jk got 1 want 0"); else passed++;
    total++; if (dn.size() != 2) $display("FAIL gap_ndone got %0d want 2", dn.size()); else passed++;
    if (dn.size() == 2) begin
      total++; if (dn[0] != 4) $display("FAIL gap_done0 got %0d want 4", dn[0]); else passed++;
      total++; if (dn[1] != 9) $display("FAIL gap_done1 got %0d want 9", dn[1]); else passed++;
    end
    total++; if (b11 !== 1'b1) $display("FAIL gap_busy11 got %b want 1", b11); else passed++;
    total++; if (b12 !== 1'b0) $display("FAIL gap_busy12 got %b want 0", b12); else passed++;
  endtask

  task automatic test_full();
    logic [1:0] ops [6];
    logic [1:0] got [$];
    int   idx = 0, first_low = -1;
    logic rd7 = 1'b0;
    bit   acc;
    ops = '{2'b10, 2'b01, 2'b11, 2'b11, 2'b10, 2'b01};
    for (int c = 0; c < 40; c++) begin
      if ({j3, k3} != 2'b00) got.push_back({j3, k3});
      if (!cr3 && first_low < 0) first_low = c;
      if (c == 7) rd7 = cr3;
      cv3 = (idx < 6);
      op3 = (idx < 6) ? ops[idx] : 2'b00;
      acc = cv3 && cr3;
      @(negedge clk);
      if (acc) idx++;
    end
    cv3 = 1'b0;
    total++; if (first_low != 5) $display("FAIL full_low got %0d want 5", first_low); else passed++;
    total++; if (rd7 !== 1'b1) $display("FAIL full_ready7 got %b want 1", rd7); else passed++;
    total++; if (idx != 6) $display("FAIL full_acc got %0d want 6", idx); else passed++;
    total++; if (got.size() != 6) $display("FAIL full_n got %0d want 6", got.size()); else passed++;
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      total++; if (got[i] !== ops[i]) $display("FAIL full_op%0d got %b want %b", i, got[i], ops[i]); else passed++;
    end
    total++; if (eq3 !== 1'b0) $display("FAIL full_expq got %b want 0", eq3); else passed++;
    total++; if (busy3 !== 1'b0) $display("FAIL full_busy got %b want 0", busy3); else passed++;
    total++; if (mm3 !== 1'b0) $display("FAIL full_mm got %b want 0", mm3); else passed++;
  endtask

  task automatic test_mid_reset();
    cv0 = 1'b1; op0 = 2'b10;
    @(negedge clk);
    @(negedge clk);
    cv0 = 1'b0;
    total++; if ({j0, k0} !== 2'b10) $display("FAIL mid_drive got %b want 10", {j0, k0}); else passed++;
    #2 rst = 1'b1;
    #1;
    total++; if ({j0, k0} !== 2'b00) $display("FAIL mid_jk got %b want 00", {j0, k0}); else passed++;
    total++; if (cr0 !== 1'b1) $display("FAIL mid_ready got %b want 1", cr0); else passed++;
    total++; if (busy0 !== 1'b0) $display("FAIL mid_busy got %b want 0", busy0); else passed++;
    total++; if (eq0 !== 1'b0) $display("FAIL mid_expq got %b want 0", eq0); else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (busy0 !== 1'b0) $display("FAIL mid_after got %b want 0", busy0); else passed++;
  endtask

  task automatic test_selfcheck();
    int  sent = 0;
    bit  ok, acc;
    logic [7:0] want_ec;
    fault = 1'b1;
    cv0 = 1'b1; op0 = 2'b10;
    @(negedge clk);
    cv0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (mm0 !== 1'b0) $display("FAIL sc_early got %b want 0", mm0); else passed++;
    @(negedge clk);
    total++; if (mm0 !== SC) $display("FAIL sc_mm1 got %b want %b", mm0, SC); else passed++;
    want_ec = SC ? 8'd1 : 8'd0;
    total++; if (ec0 !== want_ec) $display("FAIL sc_ec1 got %0d want %0d", ec0, want_ec); else passed++;
    total++; if (done0 !== 1'b1) $display("FAIL sc_done got %b want 1", done0); else passed++;
    for (int n = 0; n < 2000 && sent < 299; n++) begin
      cv0 = 1'b1; op0 = 2'b10;
      acc = cr0;
      @(negedge clk);
      if (acc) sent++;
    end
    cv0 = 1'b0;
    wait_idle0(50, ok);
    total++; if (!ok) $display("FAIL sc_idle got busy want idle"); else passed++;
    want_ec = SC ? 8'd255 : 8'd0;
    total++; if (ec0 !== want_ec) $display("FAIL sc_sat got %0d want %0d", ec0, want_ec); else passed++;
    fault = 1'b0;
    cv0 = 1'b1; op0 = 2'b01;
    @(negedge clk);
    cv0 = 1'b0;
    wait_idle0(50, ok);
    total++; if (!ok) $display("FAIL sc_idle2 got busy want idle"); else passed++;
    total++; if (mm0 !== SC) $display("FAIL sc_sticky got %b want %b", mm0, SC); else passed++;
    total++; if (ec0 !== want_ec) $display("FAIL sc_hold got %0d want %0d", ec0, want_ec); else passed++;
    total++; if (eq0 !== 1'b0) $display("FAIL sc_expq got %b want 0", eq0); else passed++;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gap_hold();
    test_full();
    test_mid_reset();
    test_selfcheck();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
